universal_shift_reg: RTL

- Parametrised successor to the team's single-bit rising-edge D flip-flop: a WIDTH-bit register with hold, shift-right, shift-left and parallel-load modes.
- Provides serial in/out at both ends and a shift counter with a done flag for serialiser/deserialiser use.
- Sits between parallel datapaths and serial links (UART/SPI-style framing) in the mini-project set.

---
 rtl/universal_shift_reg.sv | 91 +++++++++
 1 files changed

// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal shift register: hold, shift right/left, parallel load, saturating shift counter.
// Optional USR_ROTATE_EN macro adds a rot input that makes shifts rotate instead of taking serial input.
module universal_shift_reg #(
   parameter int unsigned             WIDTH     = 8,
   parameter logic [WIDTH-1:0]        RESET_VAL = {WIDTH{1'b0}},
   parameter int unsigned             CNT_W     = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             sin_r,
   input  logic             sin_l,
`ifdef USR_ROTATE_EN
   input  logic             rot,
`endif
   output logic [WIDTH-1:0] q,
   output logic             sout_r,
   output logic             sout_l,
   output logic [CNT_W-1:0] shift_cnt,
   output logic             done
);

   localparam logic [1:0]       MODE_HOLD  = 2'b00;
   localparam logic [1:0]       MODE_RIGHT = 2'b01;
   localparam logic [1:0]       MODE_LEFT  = 2'b10;
   localparam logic [1:0]       MODE_LOAD  = 2'b11;
   localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(WIDTH);

   logic [WIDTH-1:0] q_next;
   logic [CNT_W-1:0] cnt_next;
   logic [CNT_W-1:0] cnt_inc;
   logic             fill_r;
   logic             fill_l;

   // Bits entering each end: serial inputs, or the wrap-around bit when rotating
`ifdef USR_ROTATE_EN
   assign fill_r = rot ? q[0]       : sin_r;
   assign fill_l = rot ? q[WIDTH-1] : sin_l;
`else
   assign fill_r = sin_r;
   assign fill_l = sin_l;
`endif

   assign cnt_inc = (shift_cnt == CNT_MAX) ? CNT_MAX : shift_cnt + CNT_W'(1);

   always_comb begin
      q_next   = q;
      cnt_next = shift_cnt;
      if (en) begin
         case (mode)
            MODE_HOLD: begin
               q_next   = q;
               cnt_next = shift_cnt;
            end
            MODE_RIGHT: begin
               q_next   = {fill_r, q[WIDTH-1:1]};
               cnt_next = cnt_inc;
            end
            MODE_LEFT: begin
               q_next   = {q[WIDTH-2:0], fill_l};
               cnt_next = cnt_inc;
            end
            MODE_LOAD: begin
               q_next   = d;
               cnt_next = '0;
            end
            default: begin
               q_next   = q;
               cnt_next = shift_cnt;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q         <= RESET_VAL;
         shift_cnt <= '0;
      end else begin
         q         <= q_next;
         shift_cnt <= cnt_next;
      end
   end

   assign sout_r = q[0];
   assign sout_l = q[WIDTH-1];
   assign done   = (shift_cnt == CNT_MAX);

endmodule
